// File: rtl/serial_mult_dispatcher_pkg.sv
// Shared types and constants for the serial multiplier dispatcher and its operand FIFO.
// The optional watchdog is selected by SERIAL_MULT_DISPATCH_TIMEOUT_EN in the top module.
package serial_mult_dispatcher_pkg;

    localparam int SMD_WIDTH = 4;
    localparam int SMD_DEPTH = 4;
    localparam int SMD_PTR_W = $clog2(SMD_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    typedef struct packed {
        logic [SMD_WIDTH-1:0] a;
        logic [SMD_WIDTH-1:0] b;
    } operand_pair_t;

    // A depth of one still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/serial_mult_dispatcher_sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy count, used to queue operand pairs.
// DEPTH must be a power of two so the pointers wrap naturally.
module serial_mult_dispatcher_sync_fifo
    import serial_mult_dispatcher_pkg::*;
#(
    parameter int DATA_W = 2*SMD_WIDTH,
    parameter int DEPTH  = SMD_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = (DEPTH == SMD_DEPTH) ? SMD_PTR_W : ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is governed by the count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/serial_mult_dispatcher.sv
// Queues operand pairs, issues them one at a time to the serial multiplier and returns products in order.
// Define SERIAL_MULT_DISPATCH_TIMEOUT_EN to add the GUARD/WAIT watchdog and the sticky err flag.
module serial_mult_dispatcher
    import serial_mult_dispatcher_pkg::*;
#(
    parameter int WIDTH   = SMD_WIDTH,
    parameter int DEPTH   = SMD_DEPTH,
    parameter int TIMEOUT = 2*WIDTH+4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mul_valid,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_product_valid,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_data,
    output logic               err
);

    // state | meaning
    // IDLE  | wait for a queued pair and a free (or draining) result slot
    // ISSUE | mul_valid pulse, operands presented
    // GUARD | multiplier still shows the previous done level; ignored
    // WAIT  | wait for mul_product_valid, then capture into the slot
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_GUARD = ST_GUARD;
    localparam logic [1:0] S_WAIT  = ST_WAIT;

    localparam int PW = 2*WIDTH;

    logic [1:0]       state_q, state_d;
    logic             mul_valid_q, mul_valid_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic             out_valid_q, out_valid_d;
    logic [PW-1:0]    out_data_q, out_data_d;

    logic [PW-1:0]    fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             slot_free;
    logic             timeout_hit;

    serial_mult_dispatcher_sync_fifo #(
        .DATA_W (PW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .wdata_i ({in_a, in_b}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign slot_free = !out_valid_q || out_ready;

`ifdef SERIAL_MULT_DISPATCH_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;

    assign timeout_hit = (timer_q == '0);

    // Loaded on the issue cycle so it covers exactly GUARD plus WAIT.
    always_comb begin
        timer_d = timer_q;
        if (state_q == S_ISSUE) begin
            timer_d = TMR_W'(TIMEOUT - 1);
        end else if ((state_q == S_GUARD || state_q == S_WAIT) && !timeout_hit) begin
            timer_d = timer_q - TMR_W'(1);
        end
        err_d = err_q || (state_q == S_WAIT && !mul_product_valid && timeout_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT > 0);
    assign timeout_hit        = 1'b0;
    assign err                = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mul_valid_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        fifo_pop    = 1'b0;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && slot_free) begin
                    fifo_pop    = 1'b1;
                    mul_a_d     = fifo_rdata[PW-1:WIDTH];
                    mul_b_d     = fifo_rdata[WIDTH-1:0];
                    mul_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_GUARD;
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                if (mul_product_valid) begin
                    out_data_d  = mul_product;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign mul_valid = mul_valid_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_serial_mult_dispatcher.sv
// Self-checking bench: directed latency/ordering/reset scenarios plus a randomized run,
// checked against a queue-based reference of accepted pairs and a simple multiplier model.
module tb_serial_mult_dispatcher;

    localparam int WIDTH   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 2*WIDTH+4;
    localparam int PW      = 2*WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             mul_valid;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic             mul_product_valid = 1'b0;
    logic [PW-1:0]    mul_product = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [PW-1:0]    out_data;
    logic             err;

    serial_mult_dispatcher #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_a              (in_a),
        .in_b              (in_b),
        .mul_valid         (mul_valid),
        .mul_a             (mul_a),
        .mul_b             (mul_b),
        .mul_product_valid (mul_product_valid),
        .mul_product       (mul_product),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .err               (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // reference state: accepted-but-unissued pairs, issued products awaiting output
    logic [PW-1:0] acc_q[$];
    int            infl_q[$];
    int            out_log[$];
    int n_pulse = 0, n_out = 0;
    int pulse_cyc = 0, last_acc_cyc = 0, issue_lat = 0, out_lat = 0, err_lat = 0;
    bit prev_mul_valid = 0, prev_out_valid = 0, prev_out_ready = 0, prev_err = 0;
    logic [PW-1:0] prev_out_data = '0;

    // multiplier model: done level stays high until one cycle after the next pulse
    int m_cnt = 99, m_lat = 100, m_a = 0, m_b = 0;
    bit m_done = 0;
    int force_lat = 0;
    bit force_zero = 0;

    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
            infl_q.delete();
            m_cnt = 99; m_lat = 100; m_done = 0;
            mul_product_valid = 1'b0;
            mul_product = '0;
            prev_mul_valid = 0; prev_out_valid = 0; prev_out_ready = 0; prev_err = 0;
        end else begin
            logic [PW-1:0] pair;
            if (in_valid && in_ready) begin
                acc_q.push_back({in_a, in_b});
                last_acc_cyc = cyc;
            end
            if (mul_valid) begin
                check("mul_valid_gap", 32'(prev_mul_valid), 0);
                check("issue_has_pair", 32'(acc_q.size() > 0), 1);
                if (acc_q.size() > 0) begin
                    pair = acc_q.pop_front();
                    check("mul_a", 32'(mul_a), 32'(pair[PW-1:WIDTH]));
                    check("mul_b", 32'(mul_b), 32'(pair[WIDTH-1:0]));
                    infl_q.push_back(int'(pair[PW-1:WIDTH]) * int'(pair[WIDTH-1:0]));
                end
                issue_lat = cyc - last_acc_cyc;
                pulse_cyc = cyc;
                n_pulse++;
                m_cnt = 0; m_a = int'(mul_a); m_b = int'(mul_b);
                m_lat = (force_lat != 0) ? force_lat : int'($urandom_range(2, 6));
            end else if (m_cnt < 99) begin
                m_cnt++;
            end
            if (out_valid && !prev_out_valid) out_lat = cyc - pulse_cyc;
            if (out_valid && prev_out_valid && !prev_out_ready)
                check("out_hold", 32'(out_data), 32'(prev_out_data));
            if (out_valid && out_ready) begin
                check("out_has_exp", 32'(infl_q.size() > 0), 1);
                if (infl_q.size() > 0) check("out_data", 32'(out_data), 32'(infl_q.pop_front()));
                out_log.push_back(int'(out_data));
                n_out++;
            end
            if (err && !prev_err) begin
                err_lat = cyc - pulse_cyc;
                if (infl_q.size() > 0) void'(infl_q.pop_back());
            end
            prev_mul_valid = mul_valid;
            prev_out_valid = out_valid;
            prev_out_ready = out_ready;
            prev_out_data  = out_data;
            prev_err       = err;

            if (m_cnt <= 1) begin
                mul_product_valid = m_done;
                mul_product = PW'($urandom);
            end else if (m_cnt >= m_lat && !force_zero) begin
                mul_product_valid = 1'b1;
                mul_product = PW'(m_a * m_b);
                m_done = 1;
            end else begin
                mul_product_valid = 1'b0;
                mul_product = PW'($urandom);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int b);
        bit done = 0;
        in_a = WIDTH'(a);
        in_b = WIDTH'(b);
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("push_accepted", 32'(done), 1);
    endtask

    task automatic wait_outs(input int n, input int budget);
        int i = 0;
        while (n_out < n && i < budget) begin
            tick();
            i++;
        end
        check("wait_outs", 32'(n_out >= n), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(in_ready), 1);
        check({tag, "_mul_valid"}, 32'(mul_valid), 0);
        check({tag, "_mul_a"},     32'(mul_a), 0);
        check({tag, "_mul_b"},     32'(mul_b), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"},  32'(out_data), 0);
        check({tag, "_err"},       32'(err), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got time %0t expected finish", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int o0, p0, idx, first_block, guard, prods[4];

        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // single pair, multiplier answers 4 cycles after the pulse
        force_lat = 4;
        push(3, 5);
        wait_outs(1, 50);
        check("t1_issue_lat", 32'(issue_lat), 2);
        check("t1_out_lat", 32'(out_lat), 5);
        check("t1_pulses", 32'(n_pulse), 1);
        check("t1_product", 32'(out_log[0]), 15);

        // zero operand with stale done level during ISSUE/GUARD
        force_lat = 2;
        push(0, 9);
        wait_outs(2, 50);
        check("t2_out_lat", 32'(out_lat), 3);
        check("t2_product", 32'(out_log[1]), 0);

        // burst of six pairs against a four-deep FIFO
        force_lat = 0;
        o0 = n_out;
        idx = 1; first_block = -1; guard = 0;
        in_valid = 1'b1;
        while (idx <= 6 && guard < 400) begin
            in_a = WIDTH'(idx);
            in_b = WIDTH'(idx);
            @(negedge clk);
            if (in_ready) idx++;
            else if (first_block < 0) first_block = idx - 1;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        check("t3_accepts_before_full", 32'(first_block), 5);
        wait_outs(o0 + 6, 300);
        for (int k = 0; k < 6 && o0 + k < out_log.size(); k++)
            check("t3_order", 32'(out_log[o0 + k]), 32'((k + 1) * (k + 1)));

        // consumer stalls after first result
        o0 = n_out;
        p0 = n_pulse;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int a = int'($urandom_range(0, 15));
            int b = int'($urandom_range(0, 15));
            prods[k] = a * b;
            push(a, b);
        end
        repeat (40) tick();
        check("t4_single_issue", 32'(n_pulse - p0), 1);
        check("t4_slot_full", 32'(out_valid), 1);
        check("t4_slot_data", 32'(out_data), 32'(prods[0]));
        out_ready = 1'b1;
        wait_outs(o0 + 4, 300);
        for (int k = 0; k < 4 && o0 + k < out_log.size(); k++)
            check("t4_order", 32'(out_log[o0 + k]), 32'(prods[k]));

        // reset while waiting with two pairs still queued
        force_lat = 6;
        p0 = n_pulse;
        push(3, 3);
        push(4, 4);
        push(5, 5);
        guard = 0;
        while (!(n_pulse > p0 && cyc >= pulse_cyc + 3) && guard < 50) begin
            tick();
            guard++;
        end
        check("t5_in_wait", 32'(n_pulse - p0), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("t5_rst");
        p0 = n_pulse;
        repeat (8) tick();
        check("t5_flushed", 32'(n_pulse - p0), 0);
        force_lat = 0;
        o0 = n_out;
        push(2, 7);
        wait_outs(o0 + 1, 60);
        check("t5_product", 32'(out_log[out_log.size() - 1]), 14);

`ifdef SERIAL_MULT_DISPATCH_TIMEOUT_EN
        // watchdog: product never arrives for the first pair
        force_zero = 1;
        o0 = n_out;
        push(6, 2);
        push(7, 3);
        guard = 0;
        while (!err && guard < 100) begin
            tick();
            guard++;
        end
        force_zero = 0;
        check("t6_err", 32'(err), 1);
        check("t6_err_lat", 32'(err_lat), 13);
        wait_outs(o0 + 1, 60);
        check("t6_next_product", 32'(out_log[out_log.size() - 1]), 21);
        repeat (10) tick();
        check("t6_dropped", 32'(n_out - o0), 1);
        check("t6_err_sticky", 32'(err), 1);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_a      = WIDTH'($urandom);
            in_b      = WIDTH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while ((acc_q.size() > 0 || infl_q.size() > 0 || out_valid) && guard < 500) begin
            tick();
            guard++;
        end
        check("rand_drained_acc", 32'(acc_q.size()), 0);
        check("rand_drained_inflight", 32'(infl_q.size()), 0);
        check("rand_slot_empty", 32'(out_valid), 0);
`ifndef SERIAL_MULT_DISPATCH_TIMEOUT_EN
        check("err_tied_low", 32'(err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
